// File: rtl/exu_lsu.sv
// rtl/exu_lsu.sv - EXU load/store unit: one outstanding access, lane shifting and load extension.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module exu_lsu #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_w,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_r,
    input  logic              mem_rvalid
);
    localparam int LANE_W = $clog2(XLEN/8);
    localparam int STRB_W = XLEN/8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              store_q, store_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic [LANE_W-1:0]   lane;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     mask;
    logic                sign;
    logic [XLEN-1:0]     ld_data;
    logic [2*STRB_W-1:0] strb_wide;
    logic                acc_err;

    always_comb begin
        acc_err = (XLEN == 32) && (req_size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_size)
            2'd1:    acc_err = acc_err | req_addr[0];
            2'd2:    acc_err = acc_err | (|req_addr[1:0]);
            2'd3:    acc_err = acc_err | (|req_addr[2:0]);
            default: acc_err = acc_err;
        endcase
`endif
    end

    // Load data: bring the addressed lane down to bit 0, then truncate and extend.
    always_comb begin
        lane    = addr_q[LANE_W-1:0];
        shifted = mem_r >> {lane, 3'b000};
        case (size_q)
            2'd0:    begin mask = XLEN'(64'hFF);        sign = shifted[7];      end
            2'd1:    begin mask = XLEN'(64'hFFFF);      sign = shifted[15];     end
            2'd2:    begin mask = XLEN'(64'hFFFF_FFFF); sign = shifted[31];     end
            default: begin mask = '1;                   sign = shifted[XLEN-1]; end
        endcase
        ld_data = shifted & mask;
        if (!uns_q && sign) begin
            ld_data = ld_data | ~mask;
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        store_d = store_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    store_d = req_store;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = acc_err;
                    state_d = acc_err ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = store_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = ld_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    strb_wide = (2*STRB_W)'(8'h01);
            2'd1:    strb_wide = (2*STRB_W)'(8'h03);
            2'd2:    strb_wide = (2*STRB_W)'(8'h0F);
            default: strb_wide = (2*STRB_W)'(8'hFF);
        endcase
        // Strobe bits past the word boundary fall off on truncation.
        strb_wide = strb_wide << lane;

        req_ready     = (state_q == IDLE);
        resp_valid    = (state_q == RESP);
        resp_err      = (state_q == RESP) && err_q;
        resp_rdata    = (state_q == RESP) ? rdata_q : '0;
        mem_req_valid = (state_q == REQ);
        mem_r_en      = (state_q == REQ) && !store_q;
        mem_w_en      = (state_q == REQ) && store_q;
        mem_addr      = BASE_ADDR;
        mem_w         = '0;
        mem_wstrb     = '0;
        if (state_q == REQ) begin
            mem_addr = {addr_q[XLEN-1:LANE_W], {LANE_W{1'b0}}};
            if (store_q) begin
                mem_w     = wdata_q << {lane, 3'b000};
                mem_wstrb = strb_wide[STRB_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            size_q  <= '0;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            store_q <= store_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_exu_lsu.sv
// tb/tb_exu_lsu.sv - directed scoreboard bench for exu_lsu at XLEN=32.
module tb_exu_lsu;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk, rst;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_r_en, mem_w_en, mem_rvalid;
    logic [31:0] mem_addr, mem_w, mem_r;
    logic [3:0]  mem_wstrb;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    exu_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_addr(mem_addr), .mem_w(mem_w), .mem_wstrb(mem_wstrb),
        .mem_r(mem_r), .mem_rvalid(mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".req_ready"},     64'(req_ready),     64'd1);
        chk({tag, ".resp_valid"},    64'(resp_valid),    64'd0);
        chk({tag, ".resp_err"},      64'(resp_err),      64'd0);
        chk({tag, ".resp_rdata"},    64'(resp_rdata),    64'd0);
        chk({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, ".mem_r_en"},      64'(mem_r_en),      64'd0);
        chk({tag, ".mem_w_en"},      64'(mem_w_en),      64'd0);
        chk({tag, ".mem_w"},         64'(mem_w),         64'd0);
        chk({tag, ".mem_wstrb"},     64'(mem_wstrb),     64'd0);
        chk({tag, ".mem_addr"},      64'(mem_addr),      64'h8000_0000);
    endtask

    task automatic run_txn(input string tag, input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mr,
                           input logic [31:0] exp_maddr, input logic [31:0] exp_w, input logic [3:0] exp_strb,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int req_stall, input int resp_stall);
        exp_t e;
        chk({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = addr; req_wdata = wdata;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        step();
        req_valid = 1'b0; req_wdata = 32'hDEAD_0000; req_addr = 32'h0;
        if (!exp_err) begin
            mem_req_ready = 1'b0;
            for (int i = 0; i <= req_stall; i++) begin
                if (i == req_stall) mem_req_ready = 1'b1;
                else begin mem_rvalid = 1'b1; mem_r = 32'h5A5A_5A5A; end
                chk({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd1);
                chk({tag, ".mem_r_en"},      64'(mem_r_en),      64'(!st));
                chk({tag, ".mem_w_en"},      64'(mem_w_en),      64'(st));
                chk({tag, ".mem_addr"},      64'(mem_addr),      64'(exp_maddr));
                chk({tag, ".mem_w"},         64'(mem_w),         64'(st ? exp_w : 32'h0));
                chk({tag, ".mem_wstrb"},     64'(mem_wstrb),     64'(st ? exp_strb : 4'h0));
                chk({tag, ".req_ready_busy"}, 64'(req_ready),    64'd0);
                step();
                mem_rvalid = 1'b0;
            end
            mem_req_ready = 1'b0;
            if (!st) begin
                chk({tag, ".wait_no_req"}, 64'(mem_req_valid), 64'd0);
                chk({tag, ".wait_no_resp"}, 64'(resp_valid), 64'd0);
                mem_r = mr; mem_rvalid = 1'b1;
                step();
                mem_rvalid = 1'b0; mem_r = 32'h0;
            end
        end else begin
            chk({tag, ".err_no_mem"}, 64'(mem_req_valid), 64'd0);
        end
        chk({tag, ".sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        for (int i = 0; i <= resp_stall; i++) begin
            if (i == resp_stall) resp_ready = 1'b1;
            chk({tag, ".resp_valid"},    64'(resp_valid),    64'd1);
            chk({tag, ".resp_rdata"},    64'(resp_rdata),    64'(e.rdata));
            chk({tag, ".resp_err"},      64'(resp_err),      64'(e.err));
            chk({tag, ".resp_req_rdy"},  64'(req_ready),     64'd0);
            chk({tag, ".resp_no_mem"},   64'(mem_req_valid), 64'd0);
            step();
        end
        resp_ready = 1'b0;
        chk({tag, ".done_idle"}, 64'(resp_valid), 64'd0);
        chk({tag, ".done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_r = 32'h0; mem_rvalid = 1'b0;
        #2;
        chk_idle("reset");
        step(); step();
        rst = 1'b1;
        step();
        chk_idle("post_reset");

        // store byte with memory and response back-pressure
        run_txn("st_b", 1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h1234_5678, 32'h0,
                32'h8000_0000, 32'h7800_0000, 4'b1000, 32'h0, 1'b0, 3, 2);
        run_txn("ld_bs", 1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 32'h0000_F100,
                32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_FFF1, 1'b0, 0, 0);
        run_txn("ld_bu", 1'b0, 2'd0, 1'b1, 32'h8000_0001, 32'h0, 32'h0000_F100,
                32'h8000_0000, 32'h0, 4'h0, 32'h0000_00F1, 1'b0, 0, 0);
        run_txn("ld_w_mis", 1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 32'hAABB_CCDD,
                32'h8000_0000, 32'h0, 4'h0, MIS ? 32'h0 : 32'h0000_AABB, MIS, 0, 0);
        run_txn("st_h", 1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'hCAFE_BEEF, 32'h0,
                32'h8000_0000, 32'hBEEF_0000, 4'b1100, 32'h0, 1'b0, 0, 0);
        run_txn("ld_hs", 1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_1234,
                32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_8001, 1'b0, 1, 1);
        run_txn("ld_hu", 1'b0, 2'd1, 1'b1, 32'h8000_0006, 32'h0, 32'h8001_1234,
                32'h8000_0004, 32'h0, 4'h0, 32'h0000_8001, 1'b0, 0, 0);
        run_txn("dword", 1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 32'h1111_1111,
                32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 0, 0);
        run_txn("st_w", 1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,
                32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 0, 0);
        run_txn("st_h_mis", 1'b1, 2'd1, 1'b0, 32'h8000_0003, 32'h0000_BEEF, 32'h0,
                32'h8000_0000, 32'hEF00_0000, 4'b1000, 32'h0, MIS, 0, 0);
        run_txn("ld_w", 1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 32'h8765_4321,
                32'h8000_0008, 32'h0, 4'h0, 32'h8765_4321, 1'b0, 0, 0);

        // reset while waiting for load data abandons the access
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8000_0010;
        step();
        req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("rstw.in_wait", 64'(mem_req_valid | resp_valid | req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk_idle("rst_in_wait");
        step();
        rst = 1'b1;
        step();
        mem_r = 32'hCCCC_CCCC; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstw.no_resp", 64'(resp_valid), 64'd0);
            chk("rstw.ready", 64'(req_ready), 64'd1);
            step();
        end
        run_txn("after_rst", 1'b0, 2'd0, 1'b1, 32'h8000_0002, 32'h0, 32'h00AB_0000,
                32'h8000_0000, 32'h0, 4'h0, 32'h0000_00AB, 1'b0, 0, 0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
